// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM byte-port arbiter: FSM states, access size codes
// and requester IDs.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // Size code 3 is not a legal RV32I access width and is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between fetch and load/store,
// sequencing multi-byte accesses one byte per cycle and raising pipeline stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_e            state_q;
  req_e              who_q;
  logic [2:0]        cnt_q;
  logic [2:0]        nbytes_q;
  logic              we_q;
  logic [RAM_AW-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       buf_d;
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       mem_rdata_q;
  logic [1:0]        lane;
  logic [2:0]        off;
  logic              busy;
  logic              last_wr;
  logic              last_rd;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[ADDR_W-1:RAM_AW], mem_addr[ADDR_W-1:RAM_AW]};

  // RAM reads return one cycle late, so the byte arriving now belongs to lane cnt-1.
  assign lane = 2'(cnt_q - 3'd1);
  always_comb begin
    buf_d = buf_q;
    buf_d[{lane, 3'b000} +: 8] = ram_din;
  end

  // On the extra read cycle (cnt == N) the address holds at the last byte.
  assign off     = (cnt_q < nbytes_q) ? cnt_q : nbytes_q - 3'd1;
  assign busy    = (state_q == BUSY);
  assign last_wr = we_q && (cnt_q == nbytes_q - 3'd1);
  assign last_rd = !we_q && (cnt_q == nbytes_q);

  assign ram_a    = busy ? base_q + RAM_AW'(off) : '0;
  assign ram_dout = (busy && we_q) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
  assign ram_wr   = busy & we_q & ~rst;

  assign if_done   = if_done_q & ~if_flush;
  assign mem_done  = mem_done_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      who_q       <= REQ_IF;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          buf_q <= '0;
          if (mem_req) begin
            who_q    <= REQ_MEM;
            we_q     <= mem_we;
            base_q   <= mem_addr[RAM_AW-1:0];
            wdata_q  <= mem_wdata;
            nbytes_q <= size_bytes(mem_size);
            state_q  <= BUSY;
          end else if (if_req && !if_flush) begin
            who_q    <= REQ_IF;
            we_q     <= 1'b0;
            base_q   <= if_addr[RAM_AW-1:0];
            wdata_q  <= '0;
            nbytes_q <= 3'd4;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (who_q == REQ_IF && if_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            if (!we_q && cnt_q != '0) buf_q <= buf_d;
            if (last_wr || last_rd) begin
              state_q <= DONE;
              if (who_q == REQ_IF) begin
                if_done_q <= 1'b1;
                if_inst_q <= buf_d;
              end else begin
                mem_done_q <= 1'b1;
                if (!we_q) mem_rdata_q <= buf_d;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed vectors, hand-built corner sequences and random
// accesses checked against a byte-array memory model.
module tb_mem_arbiter;

  localparam int RAM_SIZE = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_wr;

  logic [7:0]  ramMem [0:RAM_SIZE-1];
  logic [7:0]  refMem [0:RAM_SIZE-1];
  logic [16:0] aLog [0:23];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic        isIf;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    int          expLat;
    int          expWr;
  } vec_t;

  vec_t vecs [0:10];

  mem_arbiter #(.ADDR_W(32), .RAM_AW(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr) ramMem[ram_a] <= ram_dout;
    ram_din <= ramMem[ram_a];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not end");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nBytes(input logic isIf, input logic [1:0] size);
    if (isIf) return 4;
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int ramIdx(input logic [31:0] a);
    return int'(a % 32'(RAM_SIZE));
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v + (32'(refMem[ramIdx(a + 32'(k))]) << (8 * k));
    return v;
  endfunction

  task automatic refStore(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) refMem[ramIdx(a + 32'(k))] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  task automatic setBoth(input int idx, input logic [7:0] v);
    ramMem[idx] = v;
    refMem[idx] = v;
  endtask

  // Runs one complete access starting in an idle cycle; returns the data, the
  // cycle (counted from the request cycle) in which done rose, and the write count.
  task automatic applyStimulus(input logic isIf, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] data, output int lat, output int writes);
    bit seen = 0;
    writes = 0;
    lat = -1;
    data = 32'd0;
    if (isIf) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end
    #1;
    aLog[0] = ram_a;
    checkOutput("stall_raised", {31'd0, isIf ? stall_if : stall_mem}, 32'd1);
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      aLog[cyc] = ram_a;
      if (ram_wr) writes++;
      if (isIf ? if_done : mem_done) begin
        seen = 1;
        lat = cyc;
        data = isIf ? if_inst : mem_rdata;
        checkOutput("stall_dropped", {31'd0, isIf ? stall_if : stall_mem}, 32'd0);
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runAndCheck(input string tag, input vec_t v);
    logic [31:0] data;
    int lat, writes, n;
    n = nBytes(v.isIf, v.size);
    applyStimulus(v.isIf, v.we, v.size, v.addr, v.wdata, data, lat, writes);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, "_writes"}, 32'(writes), 32'(v.expWr));
    if (lat > 0) checkOutput({tag, "_done_ram_a"}, 32'(aLog[lat]), 32'd0);
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s_ram_a%0d", tag, k), 32'(aLog[k + 1]), 32'(ramIdx(v.addr + 32'(k))));
    if (v.we) begin
      refStore(v.addr, n, v.wdata);
      for (int k = 0; k < n; k++)
        checkOutput($sformatf("%s_stored%0d", tag, k),
                    32'(ramMem[ramIdx(v.addr + 32'(k))]), 32'(refMem[ramIdx(v.addr + 32'(k))]));
    end else begin
      checkOutput({tag, "_data"}, data, v.expData);
    end
  endtask

  initial begin
    logic [31:0] data;
    int lat, writes, memAt, ifAt, doneCnt, wrCnt;
    vec_t v;

    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;

    for (int i = 0; i < RAM_SIZE; i++) setBoth(i, 8'($urandom));
    for (int i = 0; i < 32'h400; i++) setBoth(i, 8'h00);
    setBoth(32'h100, 8'h13); setBoth(32'h101, 8'h05); setBoth(32'h102, 8'h10); setBoth(32'h103, 8'h00);
    setBoth(32'h40, 8'h34);  setBoth(32'h41, 8'h12);
    setBoth(32'h200, 8'h93); setBoth(32'h201, 8'h00); setBoth(32'h202, 8'h50); setBoth(32'h203, 8'h00);
    setBoth(32'h1FFFF, 8'h78); setBoth(0, 8'h56); setBoth(1, 8'h34); setBoth(2, 8'h12);

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0010_0513, 6, 0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         2, 1};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0040, 32'h0,         32'h0000_1234, 4, 0};
    vecs[3]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0080, 32'hCAFE_F00D, 32'h0,         5, 4};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'h0,         32'hCAFE_F00D, 6, 0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0020, 32'h0,         32'h0000_00EF, 3, 0};
    vecs[6]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0080, 32'h0,         32'hCAFE_F00D, 6, 0};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0090, 32'h1122_3344, 32'h0,         3, 2};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0090, 32'h0,         32'h0000_3344, 6, 0};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'hFFFE_0083, 32'h0,         32'h0000_00CA, 4, 0};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0001_FFFF, 32'h0,         32'h1234_5678, 6, 0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_if_done", {31'd0, if_done}, 32'd0);
    checkOutput("reset_mem_done", {31'd0, mem_done}, 32'd0);
    checkOutput("reset_if_inst", if_inst, 32'd0);
    checkOutput("reset_mem_rdata", mem_rdata, 32'd0);
    checkOutput("reset_ram_wr", {31'd0, ram_wr}, 32'd0);
    checkOutput("reset_ram_a", 32'(ram_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i <= 10; i++) runAndCheck($sformatf("vec%0d", i), vecs[i]);

    $display("[TB] simultaneous IF and MEM requests");
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 0; mem_size = 2'd1; mem_addr = 32'h40;
    memAt = -1; ifAt = -1;
    for (int cyc = 1; cyc <= 30 && ifAt < 0; cyc++) begin
      @(posedge clk); #1;
      if (mem_done) begin
        memAt = cyc;
        checkOutput("simul_mem_rdata", mem_rdata, 32'h0000_1234);
        mem_req = 0;
      end
      if (if_done) begin
        ifAt = cyc;
        checkOutput("simul_if_inst", if_inst, 32'h0010_0513);
        if_req = 0;
      end
    end
    if_req = 0; mem_req = 0;
    checkOutput("simul_mem_cycle", 32'(memAt), 32'd4);
    checkOutput("simul_if_cycle", 32'(ifAt), 32'd11);
    @(posedge clk); @(negedge clk);

    $display("[TB] fetch aborted by flush");
    if_req = 1; if_addr = 32'h200;
    repeat (3) begin @(posedge clk); #1; end
    if_flush = 1;
    @(posedge clk); #1;
    checkOutput("flush_idle_ram_a", 32'(ram_a), 32'd0);
    if_req = 0; if_flush = 0;
    doneCnt = 0;
    repeat (8) begin @(posedge clk); #1; if (if_done) doneCnt++; end
    checkOutput("flush_no_done", 32'(doneCnt), 32'd0);
    checkOutput("flush_inst_kept", if_inst, 32'h0010_0513);
    @(negedge clk);
    v = '{1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 32'h0050_0093, 6, 0};
    runAndCheck("refetch", v);

    $display("[TB] flush in idle blocks fetch but not MEM");
    if_req = 1; if_addr = 32'h100; if_flush = 1;
    doneCnt = 0;
    repeat (3) begin @(posedge clk); #1; if (if_done) doneCnt++; end
    checkOutput("idleflush_ram_a", 32'(ram_a), 32'd0);
    checkOutput("idleflush_no_done", 32'(doneCnt), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h20, 32'h0, data, lat, writes);
    if_flush = 0;
    checkOutput("idleflush_mem_lat", 32'(lat), 32'd3);
    checkOutput("idleflush_mem_data", data, 32'h0000_00EF);

    $display("[TB] random accesses against memory model");
    for (int i = 0; i < 60; i++) begin
      v.isIf = ($urandom_range(0, 3) == 0);
      v.we = v.isIf ? 1'b0 : 1'($urandom_range(0, 1));
      v.size = 2'($urandom_range(0, 3));
      v.addr = ($urandom_range(0, 7) == 0) ? 32'h1FFF0 + 32'($urandom_range(0, 15))
                                           : 32'($urandom_range(32'h300, 32'h3FF));
      v.addr = v.addr | ($urandom & 32'hFFFE_0000);
      v.wdata = $urandom;
      v.expData = refLoad(v.addr, nBytes(v.isIf, v.size));
      v.expLat = nBytes(v.isIf, v.size) + (v.we ? 1 : 2);
      v.expWr = v.we ? nBytes(v.isIf, v.size) : 0;
      runAndCheck($sformatf("rand%0d", i), v);
    end

    $display("[TB] reset in the middle of a word store");
    setBoth(32'h300, 8'h55); setBoth(32'h301, 8'h55); setBoth(32'h302, 8'h55); setBoth(32'h303, 8'h55);
    mem_req = 1; mem_we = 1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'hA1B2_C3D4;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1; mem_req = 0;
    #1;
    checkOutput("rst_gates_ram_wr", {31'd0, ram_wr}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_if_done", {31'd0, if_done}, 32'd0);
    checkOutput("rst_mem_done", {31'd0, mem_done}, 32'd0);
    checkOutput("rst_if_inst", if_inst, 32'd0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
    checkOutput("rst_ram_a", 32'(ram_a), 32'd0);
    checkOutput("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
    @(negedge clk);
    rst = 0;
    wrCnt = 0;
    repeat (6) begin @(posedge clk); #1; if (ram_wr) wrCnt++; end
    checkOutput("rst_no_more_writes", 32'(wrCnt), 32'd0);
    checkOutput("rst_byte0", 32'(ramMem[32'h300]), 32'h0000_00D4);
    checkOutput("rst_byte2", 32'(ramMem[32'h302]), 32'h0000_0055);
    checkOutput("rst_byte3", 32'(ramMem[32'h303]), 32'h0000_0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
